// File: rtl/terminal_pkg.sv
// rtl/terminal_pkg.sv - control codes, attribute default and FSM encoding for the terminal writer
package terminal_pkg;

  localparam logic [7:0] CODE_BS      = 8'h08;
  localparam logic [7:0] CODE_NL      = 8'h13;
  localparam logic [7:0] CODE_CLS     = 8'h0C;
  localparam logic [7:0] CODE_SPACE   = 8'h20;
  localparam logic [7:0] DEFAULT_ATTR = 8'h70;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR     = 2'd1,
    SCROLL_RD = 2'd2,
    SCROLL_WR = 2'd3
  } state_t;

endpackage

// File: rtl/terminal_writer_if.sv
// rtl/terminal_writer_if.sv - UART byte input and text RAM port bundle for the terminal writer
interface terminal_writer_if #(
  parameter int ADDR_WIDTH = 12
);

  logic [7:0]            RxData;
  logic                  RxDone;
  logic [ADDR_WIDTH-1:0] RamAddr;
  logic [15:0]           RamData;
  logic                  RamWrite;
  logic [15:0]           RamRdata;

  modport master (
    input  RxData, RxDone, RamRdata,
    output RamAddr, RamData, RamWrite
  );

  modport slave (
    output RxData, RxDone, RamRdata,
    input  RamAddr, RamData, RamWrite
  );

endinterface

// File: rtl/terminal_cursor.sv
// rtl/terminal_cursor.sv - column/row cursor with an incrementally maintained linear address
module terminal_cursor #(
  parameter int COLUMNS    = 80,
  parameter int ROWS       = 30,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc_i,
  input  logic                  dec_i,
  input  logic                  nl_i,
  input  logic                  home_i,
  input  logic                  last_row_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [ADDR_WIDTH-1:0] bs_addr_o,
  output logic                  wrap_o
);

  localparam int CW = $clog2(COLUMNS);
  localparam int RW = $clog2(ROWS);
  localparam logic [CW-1:0]         COL_LAST      = CW'(COLUMNS - 1);
  localparam logic [RW-1:0]         ROW_LAST      = RW'(ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW_ADDR = ADDR_WIDTH'((ROWS - 1) * COLUMNS);

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  // Address is tracked with +/-1 and +COLUMNS-col steps so no multiplier is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (home_i) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end else if (last_row_i) begin
      col_d  = '0;
      row_d  = ROW_LAST;
      addr_d = LAST_ROW_ADDR;
    end else if (nl_i) begin
      col_d = '0;
      if (row_q == ROW_LAST) begin
        row_d  = '0;
        addr_d = '0;
      end else begin
        row_d  = row_q + RW'(1);
        addr_d = addr_q - ADDR_WIDTH'(col_q) + ADDR_WIDTH'(COLUMNS);
      end
    end else if (dec_i) begin
      if (col_q != '0) begin
        col_d  = col_q - CW'(1);
        addr_d = addr_q - ADDR_WIDTH'(1);
      end else if (row_q != '0) begin
        col_d  = COL_LAST;
        row_d  = row_q - RW'(1);
        addr_d = addr_q - ADDR_WIDTH'(1);
      end
    end else if (inc_i) begin
      addr_d = addr_q + ADDR_WIDTH'(1);
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d  = '0;
          addr_d = '0;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  assign addr_o    = addr_q;
  assign bs_addr_o = (col_q == '0 && row_q == '0) ? addr_q : addr_q - ADDR_WIDTH'(1);
  assign wrap_o    = (row_q == ROW_LAST) && (nl_i || (inc_i && col_q == COL_LAST));

endmodule

// File: rtl/terminal_writer.sv
// rtl/terminal_writer.sv - UART byte stream to 80x30 text RAM writer; TERMINAL_SCROLL_EN selects scroll on row overflow
module terminal_writer #(
  parameter int          COLUMNS      = 80,
  parameter int          ROWS         = 30,
  parameter logic [7:0]  DEFAULT_ATTR = terminal_pkg::DEFAULT_ATTR,
  parameter int          ADDR_WIDTH   = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  terminal_writer_if.master     bus,
  output logic [ADDR_WIDTH-1:0] CursorAddr_o,
  output logic                  Busy_o,
  output logic                  Overrun_o
);

  import terminal_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LAST_CELL = ADDR_WIDTH'(COLUMNS * ROWS - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;
  logic [7:0]            attr_q, attr_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [15:0]           ram_data_q, ram_data_d;
  logic                  ram_write_q, ram_write_d;
  logic                  overrun_q, overrun_d;

  logic                  cur_inc, cur_dec, cur_nl, cur_home, cur_last_row, cur_wrap;
  logic [ADDR_WIDTH-1:0] cur_addr, cur_bs_addr;
  logic                  sweep_fill;

  terminal_cursor #(
    .COLUMNS    (COLUMNS),
    .ROWS       (ROWS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_cursor (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (cur_inc),
    .dec_i      (cur_dec),
    .nl_i       (cur_nl),
    .home_i     (cur_home),
    .last_row_i (cur_last_row),
    .addr_o     (cur_addr),
    .bs_addr_o  (cur_bs_addr),
    .wrap_o     (cur_wrap)
  );

`ifdef TERMINAL_SCROLL_EN
  // phase_q gives the RAM its read-latency cycle; fill_q marks a CLEAR sweep that only blanks the last row.
  logic phase_q, phase_d, fill_q, fill_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= 1'b0;
      fill_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      fill_q  <= fill_d;
    end
  end

  assign sweep_fill = fill_q;
`else
  logic unused_sig;
  assign unused_sig = ^{bus.RamRdata, cur_wrap};
  assign sweep_fill = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sweep_q     <= '0;
      attr_q      <= DEFAULT_ATTR;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      ram_write_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      attr_q      <= attr_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      ram_write_q <= ram_write_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sweep_d      = sweep_q;
    attr_d       = attr_q;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    ram_write_d  = 1'b0;
    overrun_d    = bus.RxDone && (state_q != IDLE);
    cur_inc      = 1'b0;
    cur_dec      = 1'b0;
    cur_nl       = 1'b0;
    cur_home     = 1'b0;
    cur_last_row = 1'b0;
`ifdef TERMINAL_SCROLL_EN
    phase_d      = phase_q;
    fill_d       = fill_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.RxDone) begin
          if (bus.RxData[7]) begin
            attr_d = {1'b0, bus.RxData[6:0]};
          end else if (bus.RxData == CODE_BS) begin
            cur_dec     = 1'b1;
            ram_write_d = 1'b1;
            ram_addr_d  = cur_bs_addr;
            ram_data_d  = {attr_q, CODE_SPACE};
          end else if (bus.RxData == CODE_NL) begin
            cur_nl = 1'b1;
          end else if (bus.RxData == CODE_CLS) begin
            state_d = CLEAR;
            sweep_d = '0;
`ifdef TERMINAL_SCROLL_EN
            fill_d  = 1'b0;
`endif
          end else begin
            cur_inc     = 1'b1;
            ram_write_d = 1'b1;
            ram_addr_d  = cur_addr;
            ram_data_d  = {attr_q, bus.RxData};
          end
`ifdef TERMINAL_SCROLL_EN
          if (cur_wrap) begin
            state_d = SCROLL_RD;
            sweep_d = ADDR_WIDTH'(COLUMNS);
            phase_d = 1'b0;
          end
`endif
        end
      end
      CLEAR: begin
        ram_write_d = 1'b1;
        ram_addr_d  = sweep_q;
        ram_data_d  = sweep_fill ? {attr_q, CODE_SPACE} : {DEFAULT_ATTR, CODE_SPACE};
        if (sweep_q == LAST_CELL) begin
          state_d = IDLE;
          if (sweep_fill) begin
            cur_last_row = 1'b1;
          end else begin
            cur_home = 1'b1;
            attr_d   = DEFAULT_ATTR;
          end
        end else begin
          sweep_d = sweep_q + ADDR_WIDTH'(1);
        end
      end
`ifdef TERMINAL_SCROLL_EN
      SCROLL_RD: begin
        ram_addr_d = sweep_q;
        if (phase_q) begin
          state_d = SCROLL_WR;
          phase_d = 1'b0;
        end else begin
          phase_d = 1'b1;
        end
      end
      SCROLL_WR: begin
        ram_write_d = 1'b1;
        ram_addr_d  = sweep_q - ADDR_WIDTH'(COLUMNS);
        ram_data_d  = bus.RamRdata;
        if (sweep_q == LAST_CELL) begin
          state_d = CLEAR;
          sweep_d = ADDR_WIDTH'(COLUMNS * (ROWS - 1));
          fill_d  = 1'b1;
        end else begin
          state_d = SCROLL_RD;
          sweep_d = sweep_q + ADDR_WIDTH'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign bus.RamAddr  = ram_addr_q;
  assign bus.RamData  = ram_data_q;
  assign bus.RamWrite = ram_write_q;
  assign CursorAddr_o = cur_addr;
  assign Busy_o       = (state_q != IDLE);
  assign Overrun_o    = overrun_q;

endmodule

// File: tb/tb_terminal_writer.sv
// tb/tb_terminal_writer.sv - directed self-checking bench for terminal_writer with a text RAM model
module tb_terminal_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] CursorAddr_o;
  logic        Busy_o;
  logic        Overrun_o;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt   = 0;

  logic [15:0] mem [0:4095];

  terminal_writer_if #(.ADDR_WIDTH(12)) bus ();

  terminal_writer #(
    .COLUMNS      (80),
    .ROWS         (30),
    .DEFAULT_ATTR (8'h70),
    .ADDR_WIDTH   (12)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .CursorAddr_o (CursorAddr_o),
    .Busy_o       (Busy_o),
    .Overrun_o    (Overrun_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.RamWrite) begin
      mem[bus.RamAddr] <= bus.RamData;
      wr_cnt <= wr_cnt + 1;
    end
    bus.RamRdata <= mem[bus.RamAddr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.RxData = b;
    bus.RxDone = 1'b1;
    @(negedge clk);
    bus.RxDone = 1'b0;
  endtask

  task automatic check_write(input string tag, input logic [11:0] addr, input logic [15:0] data);
    check({tag, "_we"},   32'(bus.RamWrite), 32'd1);
    check({tag, "_addr"}, 32'(bus.RamAddr),  32'(addr));
    check({tag, "_data"}, 32'(bus.RamData),  32'(data));
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while (Busy_o && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(Busy_o), 32'd0);
  endtask

  initial begin
    int busy_cnt;
    int ovr_cnt;
    int bad_cells;
    int snap;
    int hit;

    bus.RxData = 8'h00;
    bus.RxDone = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_we",      32'(bus.RamWrite), 32'd0);
    check("rst_addr",    32'(bus.RamAddr),  32'd0);
    check("rst_data",    32'(bus.RamData),  32'd0);
    check("rst_cursor",  32'(CursorAddr_o), 32'd0);
    check("rst_busy",    32'(Busy_o),       32'd0);
    check("rst_overrun", 32'(Overrun_o),    32'd0);

    send_byte(8'h41); check_write("t1_A", 12'd0, 16'h7041);
    send_byte(8'h42); check_write("t1_B", 12'd1, 16'h7042);
    send_byte(8'h43); check_write("t1_C", 12'd2, 16'h7043);
    check("t1_cursor", 32'(CursorAddr_o), 32'd3);

    send_byte(8'hC1);
    check("t2_colour_nowrite", 32'(bus.RamWrite), 32'd0);
    check("t2_colour_cursor",  32'(CursorAddr_o), 32'd3);
    send_byte(8'h44); check_write("t2_D", 12'd3, 16'h4144);

    send_byte(8'h45); check_write("t3_E", 12'd4, 16'h4145);
    send_byte(8'h08); check_write("t3_bs", 12'd4, 16'h4120);
    check("t3_bs_cursor", 32'(CursorAddr_o), 32'd4);
    send_byte(8'h46); check_write("t3_F", 12'd4, 16'h4146);
    check("t3_cursor", 32'(CursorAddr_o), 32'd5);

    send_byte(8'h13);
    check("nl_nowrite", 32'(bus.RamWrite), 32'd0);
    check("nl_cursor",  32'(CursorAddr_o), 32'd80);
    send_byte(8'h08); check_write("bs_rowwrap", 12'd79, 16'h4120);
    check("bs_rowwrap_cursor", 32'(CursorAddr_o), 32'd79);

    for (int i = 0; i < 29; i++) send_byte(8'h13);
    check("t4_nl_cursor", 32'(CursorAddr_o), 32'd2320);
    for (int i = 0; i < 79; i++) send_byte(8'h2E);
    check("t4_fill_cursor", 32'(CursorAddr_o), 32'd2399);
    send_byte(8'h58); check_write("t4_X", 12'd2399, 16'h4158);
`ifdef TERMINAL_SCROLL_EN
    check("t4_scroll_busy", 32'(Busy_o), 32'd1);
    wait_idle("t4_scroll_timeout", 10000);
    repeat (2) @(negedge clk);
    check("t4_scroll_cursor", 32'(CursorAddr_o), 32'd2320);
    check("t4_scroll_moved",  32'(mem[2319]),    32'h4158);
    check("t4_scroll_blank",  32'(mem[2399]),    32'h4120);
    send_byte(8'h59); check_write("t4_Y", 12'd2320, 16'h4159);
    check("t4_Y_cursor", 32'(CursorAddr_o), 32'd2321);
`else
    check("t4_wrap_cursor", 32'(CursorAddr_o), 32'd0);
    check("t4_wrap_busy",   32'(Busy_o),       32'd0);
    send_byte(8'h59); check_write("t4_Y", 12'd0, 16'h4159);
    check("t4_Y_cursor", 32'(CursorAddr_o), 32'd1);
`endif

    send_byte(8'h0C);
    busy_cnt = Busy_o ? 1 : 0;
    ovr_cnt  = Overrun_o ? 1 : 0;
    for (int i = 1; i < 3000 && Busy_o; i++) begin
      if (i == 10) begin
        bus.RxData = 8'h5A;
        bus.RxDone = 1'b1;
      end else begin
        bus.RxDone = 1'b0;
      end
      @(negedge clk);
      if (Busy_o) busy_cnt++;
      if (Overrun_o) ovr_cnt++;
    end
    bus.RxDone = 1'b0;
    check("t5_sweep_end",    32'(Busy_o), 32'd0);
    check("t5_busy_cycles",  32'(busy_cnt), 32'd2400);
    check("t5_overrun_once", 32'(ovr_cnt),  32'd1);
    repeat (2) @(negedge clk);
    bad_cells = 0;
    for (int a = 0; a < 2400; a++) if (mem[a] !== 16'h7020) bad_cells++;
    check("t5_ram_cleared", 32'(bad_cells), 32'd0);
    check("t5_cursor_home", 32'(CursorAddr_o), 32'd0);
    send_byte(8'h61); check_write("t5_attr_reset", 12'd0, 16'h7061);

    send_byte(8'h0C);
    hit = 0;
    for (int i = 0; i < 3000 && hit == 0; i++) begin
      @(negedge clk);
      if (bus.RamWrite && bus.RamAddr == 12'd1000) hit = 1;
    end
    check("t6_reach_1000", 32'(hit), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_we",     32'(bus.RamWrite), 32'd0);
    check("t6_rst_busy",   32'(Busy_o),       32'd0);
    check("t6_rst_cursor", 32'(CursorAddr_o), 32'd0);
    snap = wr_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_no_more_writes", 32'(wr_cnt), 32'(snap));
    check("t6_idle_busy",      32'(Busy_o), 32'd0);

    send_byte(8'h08); check_write("bs_origin", 12'd0, 16'h7020);
    check("bs_origin_cursor", 32'(CursorAddr_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
